// File: rtl/config_initiator.sv
// ============================================================================
// config_initiator
// ----------------------------------------------------------------------------
// Host-side initiator for the smart-home configuration port. Configuration
// words (2-bit password + 35-bit confdata) are queued in a small FIFO and
// played out one at a time to the control unit as a request/confirm
// transaction:
//
//   IDLE -> REQ -> PWD -> DAT -> WAIT -> IDLE
//
// The control unit's 3-bit debug state is the completion status. CU_IDLE
// means the word was accepted (done). CU_LOCK means the password was
// rejected (err).
//
// Optional feature macro: CFGI_TIMEOUT_EN
//   defined   : a watchdog counter in WAIT raises err and drops the word
//               after TIMEOUT cycles with no resolution.
//   undefined : WAIT holds until the control unit resolves.
//
// Ports
//   clk_i          clock, rising edge
//   arst_i         synchronous active-high reset
//   push_valid_i   enqueue request
//   push_ready_o   queue not full
//   push_pw_i      password for the queued word
//   push_data_i    confdata for the queued word
//   cu_state_i     control-unit state (dbg_state)
//   request_o      transaction-start pulse to the control unit
//   confirm_o      phase-confirm pulse to the control unit
//   password_o     password bus (zero outside PWD)
//   confdata_o     configuration data bus (zero outside DAT)
//   busy_o         transaction in flight
//   done_o         1-cycle pulse: word accepted
//   err_o          1-cycle pulse: word rejected or timed out
//   count_o        number of queued words
// ============================================================================
module config_initiator #(
    parameter int         DEPTH   = 4,
    parameter int         GAP     = 2,
    parameter logic [2:0] CU_IDLE = 3'b000,
    parameter logic [2:0] CU_LOCK = 3'b111
`ifdef CFGI_TIMEOUT_EN
    ,
    parameter int         TIMEOUT = 64
`endif
) (
    input  logic                     clk_i,
    input  logic                     arst_i,
    input  logic                     push_valid_i,
    output logic                     push_ready_o,
    input  logic [1:0]               push_pw_i,
    input  logic [34:0]              push_data_i,
    input  logic [2:0]               cu_state_i,
    output logic                     request_o,
    output logic                     confirm_o,
    output logic [1:0]               password_o,
    output logic [34:0]              confdata_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     err_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int GW = $clog2(GAP + 1);
`ifdef CFGI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
`endif

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        PWD  = 3'd2,
        DAT  = 3'd3,
        WAIT = 3'd4
    } state_e;

    state_e          state_q, state_d;

    logic [36:0]     mem_q [DEPTH];
    logic [AW-1:0]   wrPtr_q;
    logic [AW-1:0]   rdPtr_q;
    logic [CW-1:0]   count_q;

    logic [1:0]      holdPw_q, holdPw_d;
    logic [34:0]     holdData_q, holdData_d;
    logic [GW-1:0]   gapCnt_q, gapCnt_d;
    logic            done_q, done_d;
    logic            err_q, err_d;
`ifdef CFGI_TIMEOUT_EN
    logic [TW-1:0]   waitCnt_q, waitCnt_d;
`else
    logic            waitFirst_q, waitFirst_d;
`endif

    logic            pushFire;
    logic            popFire;
    logic            gapDone;

    // push_ready depends only on the registered count, so a pop in the same
    // cycle never opens a slot for that cycle's push.
    assign push_ready_o = (count_q != CW'(DEPTH));
    assign pushFire     = push_valid_i && push_ready_o;
    assign gapDone      = (gapCnt_q == GW'(GAP));

    // Queue storage. It has no reset because the pointers and count define
    // which entries are valid.
    always_ff @(posedge clk_i) begin
        if (pushFire) begin
            mem_q[wrPtr_q] <= {push_pw_i, push_data_i};
        end
    end

    // Queue pointers and occupancy. The pointers wrap naturally because
    // DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (pushFire) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (popFire) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({pushFire, popFire})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FSM and hold registers. Reset drops any in-flight word silently.
    always_ff @(posedge clk_i) begin
        if (arst_i) begin
            state_q     <= IDLE;
            holdPw_q    <= '0;
            holdData_q  <= '0;
            gapCnt_q    <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
`ifdef CFGI_TIMEOUT_EN
            waitCnt_q   <= '0;
`else
            waitFirst_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            holdPw_q    <= holdPw_d;
            holdData_q  <= holdData_d;
            gapCnt_q    <= gapCnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
`ifdef CFGI_TIMEOUT_EN
            waitCnt_q   <= waitCnt_d;
`else
            waitFirst_q <= waitFirst_d;
`endif
        end
    end

    // Next-state logic. done/err are registered so that they pulse in the
    // cycle the FSM is back in IDLE. WAIT ignores cu_state in its first
    // cycle, because the control unit has not yet reacted to the final
    // confirm.
    always_comb begin
        state_d     = state_q;
        holdPw_d    = holdPw_q;
        holdData_d  = holdData_q;
        gapCnt_d    = gapCnt_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        popFire     = 1'b0;
`ifdef CFGI_TIMEOUT_EN
        waitCnt_d   = waitCnt_q;
`else
        waitFirst_d = waitFirst_q;
`endif

        case (state_q)
            IDLE: begin
                if ((count_q != '0) && (cu_state_i == CU_IDLE)) begin
                    popFire    = 1'b1;
                    holdPw_d   = mem_q[rdPtr_q][36:35];
                    holdData_d = mem_q[rdPtr_q][34:0];
                    state_d    = REQ;
                end
            end
            REQ: begin
                gapCnt_d = '0;
                state_d  = PWD;
            end
            PWD: begin
                if (gapDone) begin
                    gapCnt_d = '0;
                    state_d  = DAT;
                end else begin
                    gapCnt_d = gapCnt_q + GW'(1);
                end
            end
            DAT: begin
                if (gapDone) begin
                    gapCnt_d    = '0;
                    state_d     = WAIT;
`ifdef CFGI_TIMEOUT_EN
                    waitCnt_d   = '0;
`else
                    waitFirst_d = 1'b1;
`endif
                end else begin
                    gapCnt_d = gapCnt_q + GW'(1);
                end
            end
            WAIT: begin
`ifdef CFGI_TIMEOUT_EN
                waitCnt_d = waitCnt_q + TW'(1);
                if ((waitCnt_q != '0) && (cu_state_i == CU_LOCK)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if ((waitCnt_q != '0) && (cu_state_i == CU_IDLE)) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else if (waitCnt_q == TW'(TIMEOUT - 1)) begin
                    // err lands TIMEOUT cycles after WAIT entry.
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`else
                if (waitFirst_q) begin
                    waitFirst_d = 1'b0;
                end else if (cu_state_i == CU_LOCK) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else if (cu_state_i == CU_IDLE) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus outputs are decoded from the registered state. request and confirm
    // live in disjoint states, so they can never be high together.
    assign request_o  = (state_q == REQ);
    assign confirm_o  = ((state_q == PWD) || (state_q == DAT)) && gapDone;
    assign password_o = (state_q == PWD) ? holdPw_q : 2'b00;
    assign confdata_o = (state_q == DAT) ? holdData_q : 35'd0;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = done_q;
    assign err_o      = err_q;
    assign count_o    = count_q;

endmodule

// File: tb/tb_config_initiator.sv
// ============================================================================
// tb_config_initiator
// ----------------------------------------------------------------------------
// Directed self-checking bench for config_initiator (DEPTH=4, GAP=2).
// Pushed words go into a scoreboard queue. Each transaction the DUT plays out
// pops the head and compares password and confdata on the confirm cycles.
// ============================================================================
module tb_config_initiator;

    localparam int         GAP     = 2;
    localparam logic [2:0] CU_IDLE = 3'b000;
    localparam logic [2:0] CU_LOCK = 3'b111;

    typedef struct packed {
        logic [1:0]  pw;
        logic [34:0] data;
    } word_t;

    logic        clk = 1'b0;
    logic        arst;
    logic        pushValid;
    logic        pushReady;
    logic [1:0]  pushPw;
    logic [34:0] pushData;
    logic [2:0]  cuState;
    logic        request;
    logic        confirm;
    logic [1:0]  password;
    logic [34:0] confdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [2:0]  count;

    int          checkCount = 0;
    int          errorCount = 0;
    bit          monitorOn  = 1'b0;
    word_t       expQ[$];

    config_initiator dut (
        .clk_i        (clk),
        .arst_i       (arst),
        .push_valid_i (pushValid),
        .push_ready_o (pushReady),
        .push_pw_i    (pushPw),
        .push_data_i  (pushData),
        .cu_state_i   (cuState),
        .request_o    (request),
        .confirm_o    (confirm),
        .password_o   (password),
        .confdata_o   (confdata),
        .busy_o       (busy),
        .done_o       (done),
        .err_o        (err),
        .count_o      (count)
    );

    always #5 clk = ~clk;

    // Hard stop in case the stimulus itself gets stuck.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=no finish required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // One push cycle. expectAccept is the bench's own view of queue space.
    task automatic applyStimulus(input logic [1:0] pw, input logic [34:0] data,
                                 input bit expectAccept);
        pushValid = 1'b1;
        pushPw    = pw;
        pushData  = data;
        checkOutput("pushReady", pushReady, expectAccept);
        if (expectAccept) begin
            expQ.push_back('{pw: pw, data: data});
        end
        tick();
        pushValid = 1'b0;
    endtask

    // Follows one transaction from request through DAT. Returns at the first
    // WAIT cycle.
    task automatic runToWait();
        word_t exp;
        int    k;
        k = 0;
        while (!request && k < 50) begin
            tick();
            k++;
        end
        checkOutput("requestSeen", request, 1);
        exp = (expQ.size() > 0) ? expQ.pop_front() : '0;
        tick();
        checkOutput("requestOneCycle", request, 0);
        k = 0;
        while (!confirm && k < 20) begin
            tick();
            k++;
        end
        checkOutput("pwdGap", k, GAP);
        checkOutput("passwordBus", password, exp.pw);
        checkOutput("confdataZeroInPwd", confdata, 0);
        tick();
        checkOutput("confirmOneCycle", confirm, 0);
        checkOutput("passwordZeroInDat", password, 0);
        k = 0;
        while (!confirm && k < 20) begin
            tick();
            k++;
        end
        checkOutput("datGap", k, GAP);
        checkOutput("confdataBus", confdata, exp.data);
        tick();
        checkOutput("confdataZeroInWait", confdata, 0);
        checkOutput("busyInWait", busy, 1);
    endtask

    // Holds cu_state at 3'b010 for 'hold' WAIT cycles, then drives finalCu.
    // The first WAIT cycle is ignored, so the result shows up
    // max(hold,1)+1 cycles after WAIT entry.
    task automatic resolveWait(input int hold, input logic [2:0] finalCu,
                               input bit expectErr, input logic [2:0] nextCu);
        int k;
        k = 0;
        cuState = (hold == 0) ? finalCu : 3'b010;
        while (!(done || err) && k < 100) begin
            tick();
            k++;
            if (k == hold) cuState = finalCu;
        end
        checkOutput("waitLatency", k, ((hold > 1) ? hold : 1) + 1);
        checkOutput("doneFlag", done, !expectErr);
        checkOutput("errFlag", err, expectErr);
        checkOutput("idleOnResult", busy, 0);
        cuState = nextCu;
        tick();
        checkOutput("pulseClears", {done, err}, 2'b00);
    endtask

    // Protocol invariants, checked every cycle once out of reset.
    always @(negedge clk) begin
        if (monitorOn && !arst) begin
            checkOutput("reqConfirmExclusive", request && confirm, 0);
            checkOutput("doneErrExclusive", done && err, 0);
        end
    end

    initial begin
        int k;
        bit sawPulse;
        bit sawBusy;

        arst      = 1'b1;
        pushValid = 1'b0;
        pushPw    = '0;
        pushData  = '0;
        cuState   = CU_IDLE;
        tick();
        tick();
        checkOutput("resetPushReady", pushReady, 1);
        checkOutput("resetCount", count, 0);
        checkOutput("resetOutputs", {request, confirm, busy, done, err, password, confdata}, 0);
        arst = 1'b0;
        tick();
        monitorOn = 1'b1;
        checkOutput("postResetIdle", busy, 0);

        $display("[TB] single word accepted");
        applyStimulus(2'b10, 35'h1_2345_6789, 1);
        checkOutput("countAfterPush", count, 1);
        runToWait();
        checkOutput("countAfterPop", count, 0);
        resolveWait(3, CU_IDLE, 0, CU_IDLE);

        $display("[TB] fill queue");
        cuState = 3'b001;
        applyStimulus(2'b01, 35'h0_0000_00A1, 1);
        applyStimulus(2'b11, 35'h7_FFFF_FFFF, 1);
        applyStimulus(2'b00, 35'h4_5555_AAAA, 1);
        applyStimulus(2'b10, 35'h2_0F0F_0F0F, 1);
        checkOutput("fullNotReady", pushReady, 0);
        checkOutput("countFull", count, 4);
        applyStimulus(2'b11, 35'h1_1111_1111, 0);
        checkOutput("countAfterDroppedPush", count, 4);
        checkOutput("noStartWhileCuBusy", busy, 0);

        $display("[TB] lockout then next word");
        cuState = CU_IDLE;
        runToWait();
        resolveWait(0, CU_LOCK, 1, CU_IDLE);
        checkOutput("nextWordStarts", request, 1);
        checkOutput("countAfterSecondPop", count, 2);
        runToWait();
        resolveWait(1, CU_IDLE, 0, CU_IDLE);
        checkOutput("thirdWordStarts", request, 1);

        $display("[TB] reset during DAT");
        for (int i = 0; i < GAP + 2; i++) tick();
        checkOutput("inDatBeforeReset", confdata, expQ[0].data);
        arst = 1'b1;
        tick();
        checkOutput("rstCount", count, 0);
        checkOutput("rstPushReady", pushReady, 1);
        checkOutput("rstOutputs", {request, confirm, busy, done, err, password, confdata}, 0);
        arst = 1'b0;
        expQ.delete();
        sawPulse = 1'b0;
        sawBusy  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            sawPulse |= done | err;
            sawBusy  |= busy;
        end
        checkOutput("noPulseAfterReset", sawPulse, 0);
        checkOutput("noStartAfterReset", sawBusy, 0);

        $display("[TB] stuck control unit in WAIT");
        applyStimulus(2'b01, 35'h3_CAFE_BABE, 1);
        runToWait();
        cuState = 3'b010;
`ifdef CFGI_TIMEOUT_EN
        k = 0;
        while (!err && k < 300) begin
            tick();
            k++;
        end
        checkOutput("timeoutLatency", k, 64);
        checkOutput("timeoutErr", err, 1);
        checkOutput("timeoutNoDone", done, 0);
`else
        sawPulse = 1'b0;
        for (k = 0; k < 200; k++) begin
            tick();
            sawPulse |= done | err;
        end
        checkOutput("noTimeoutPulse", sawPulse, 0);
        checkOutput("stillWaiting", busy, 1);
        cuState = CU_IDLE;
        tick();
        checkOutput("lateDone", done, 1);
`endif
        tick();
        monitorOn = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule
